// File: rtl/hazard_tracker.sv
// ============================================================================
// hazard_tracker
// ----------------------------------------------------------------------------
// Pipeline hazard unit that sits right after the ID-stage register-index
// decoder. It remembers the destination tags of the instructions currently in
// EX, MEM and WB. From those tags it produces:
//   - the load-use and HI/LO stall,
//   - the operand forwarding selects,
//   - a busy indication for the multi-cycle multiply/divide unit.
//
// Tag encoding: 0 = none/$zero (never matches), 1..31 = GPRs, HILO_TAG = HI/LO.
//
// Parameters
//   MULDIV_LAT   cycles the mul/div unit stays busy after a MULTU/DIVU enters
//                EX (must be >= 2)
//   HILO_TAG     tag value that denotes the HI/LO register pair
//
// Ports
//   clk           in   pipeline clock, rising edge
//   rst           in   asynchronous active-high reset
//   id_valid      in   ID holds a real instruction
//   id_rs         in   ID read tag 1
//   id_rt         in   ID read tag 2
//   id_wr         in   ID write tag
//   id_is_load    in   ID instruction is a load
//   id_is_muldiv  in   ID instruction is MULTU/DIVU
//   flush         in   squash the ID instruction (taken branch/jump)
//   hold          in   global freeze
//   stall         out  hold PC and IF/ID, bubble into EX
//   fwd_a         out  operand A source: 0 regfile, 1 EX, 2 MEM, 3 WB
//   fwd_b         out  operand B source, same encoding
//   muldiv_busy   out  mul/div busy counter is non-zero
// ============================================================================
module hazard_tracker #(
    parameter int          MULDIV_LAT = 32,
    parameter logic [5:0]  HILO_TAG   = 6'd33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [5:0] id_rs,
    input  logic [5:0] id_rt,
    input  logic [5:0] id_wr,
    input  logic       id_is_load,
    input  logic       id_is_muldiv,
    input  logic       flush,
    input  logic       hold,
    output logic       stall,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       muldiv_busy
);

    localparam int             CNT_W   = $clog2(MULDIV_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MULDIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Destination tags and load flags of the instructions further down the pipe.
    logic [5:0]       ex_tag;
    logic [5:0]       mem_tag;
    logic [5:0]       wb_tag;
    logic             ex_load;
    logic             mem_load;
    logic [CNT_W-1:0] busy_cnt;

    logic             issue_ok;
    logic             load_use;
    logic             hilo_busy;
    logic             enter_ex;

    // mem_load follows the load down the pipe for MEM-stage consumers; none of
    // this block's own outputs depend on it, so it is tied off here.
    logic             unused_mem_load;
    assign unused_mem_load = mem_load;

    // Hazard detection. Nothing can stall when ID is empty, being squashed, or
    // the whole pipe is frozen, so all hazard terms are qualified by issue_ok.
    // A flush therefore always beats a hazard: the squashed instruction never
    // needs its operands, and a bubble goes into EX instead.
    // The HI/LO check is deliberately conservative: any instruction touching
    // HI/LO, or another mul/div, waits until the unit has drained.
    always_comb begin
        issue_ok  = id_valid & ~flush & ~hold;
        load_use  = 1'b0;
        hilo_busy = 1'b0;
        if (issue_ok) begin
            load_use = ex_load && (ex_tag != 6'd0) &&
                       ((ex_tag == id_rs) || (ex_tag == id_rt));
            hilo_busy = (busy_cnt != '0) &&
                        ((id_rs == HILO_TAG) || (id_rt == HILO_TAG) ||
                         (id_wr == HILO_TAG) || id_is_muldiv);
        end
        stall       = load_use | hilo_busy;
        enter_ex    = id_valid & ~flush & ~stall;
        muldiv_busy = (busy_cnt != '0);
    end

    // Operand A forwarding, nearest producer first. A load still in EX has no
    // data yet, so EX only forwards for non-loads; the load-use stall covers
    // that case and the value is picked up from MEM on the next cycle.
    // Selects are produced even while stalled; consumers ignore them then.
    always_comb begin
        fwd_a = 2'd0;
        if (id_rs != 6'd0) begin
            if ((ex_tag == id_rs) && !ex_load) begin
                fwd_a = 2'd1;
            end else if (mem_tag == id_rs) begin
                fwd_a = 2'd2;
            end else if (wb_tag == id_rs) begin
                fwd_a = 2'd3;
            end
        end
    end

    // Operand B forwarding, same priority rules as operand A but keyed on rt.
    always_comb begin
        fwd_b = 2'd0;
        if (id_rt != 6'd0) begin
            if ((ex_tag == id_rt) && !ex_load) begin
                fwd_b = 2'd1;
            end else if (mem_tag == id_rt) begin
                fwd_b = 2'd2;
            end else if (wb_tag == id_rt) begin
                fwd_b = 2'd3;
            end
        end
    end

    // Pipeline tag shift register. Everything freezes under hold. Otherwise the
    // tags march EX -> MEM -> WB, and EX receives either the ID instruction or
    // a bubble (tag 0, not a load) when ID is empty, squashed or stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_tag   <= 6'd0;
            mem_tag  <= 6'd0;
            wb_tag   <= 6'd0;
            ex_load  <= 1'b0;
            mem_load <= 1'b0;
        end else if (!hold) begin
            wb_tag   <= mem_tag;
            mem_tag  <= ex_tag;
            mem_load <= ex_load;
            if (enter_ex) begin
                ex_tag  <= id_wr;
                ex_load <= id_is_load;
            end else begin
                ex_tag  <= 6'd0;
                ex_load <= 1'b0;
            end
        end
    end

    // Mul/div busy counter. It reloads when a MULTU/DIVU actually enters EX and
    // then counts down to zero. A second mul/div cannot reload it early because
    // it is stalled while the counter is non-zero. Hold freezes the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (!hold) begin
            if (enter_ex && id_is_muldiv) begin
                busy_cnt <= LAT_CNT;
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// ============================================================================
// tb_hazard_tracker
// ----------------------------------------------------------------------------
// Self-checking bench for hazard_tracker. A reference model holds the EX/MEM/WB
// contents as a small array that shifts whenever the pipe advances, and keeps
// the mul/div unit's state as "the advance count at which the last mul/div
// entered EX": the unit is busy while fewer than MULDIV_LAT advances have
// happened since then. Directed scenarios come first, then random traffic.
// ============================================================================
module tb_hazard_tracker;

    localparam int         MD_LAT = 4;
    localparam logic [5:0] HILO   = 6'd33;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_rs;
    logic [5:0] id_rt;
    logic [5:0] id_wr;
    logic       id_is_load;
    logic       id_is_muldiv;
    logic       flush;
    logic       hold;
    logic       stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       muldiv_busy;

    always #5 clk = ~clk;

    hazard_tracker #(
        .MULDIV_LAT (MD_LAT),
        .HILO_TAG   (HILO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_wr        (id_wr),
        .id_is_load   (id_is_load),
        .id_is_muldiv (id_is_muldiv),
        .flush        (flush),
        .hold         (hold),
        .stall        (stall),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .muldiv_busy  (muldiv_busy)
    );

    int checks = 0;
    int fails  = 0;

    // Model: index 0 = EX, 1 = MEM, 2 = WB.
    logic [5:0] m_tag [3];
    logic       m_load[3];
    longint     adv;
    longint     last_md;
    logic       exp_stall;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void resetModel();
        for (int i = 0; i < 3; i++) begin
            m_tag[i]  = 6'd0;
            m_load[i] = 1'b0;
        end
        adv     = 0;
        last_md = -1000;
    endfunction

    function automatic logic modelBusy();
        return (adv - last_md) < MD_LAT;
    endfunction

    function automatic logic [1:0] modelFwd(input logic [5:0] src);
        if (src == 6'd0)                        return 2'd0;
        if (m_tag[0] == src && !m_load[0])      return 2'd1;
        if (m_tag[1] == src)                    return 2'd2;
        if (m_tag[2] == src)                    return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic modelStall();
        logic ok;
        logic lu;
        logic hb;
        ok = id_valid && !flush && !hold;
        lu = ok && m_load[0] && (m_tag[0] != 6'd0) &&
             (m_tag[0] == id_rs || m_tag[0] == id_rt);
        hb = ok && modelBusy() &&
             (id_rs == HILO || id_rt == HILO || id_wr == HILO || id_is_muldiv);
        return lu || hb;
    endfunction

    // Drive one ID-stage instruction and check all outputs against the model.
    task automatic applyStimulus(input logic v, input logic [5:0] rs, input logic [5:0] rt,
                                 input logic [5:0] wr, input logic ld, input logic md,
                                 input logic fl, input logic hd);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_wr        = wr;
        id_is_load   = ld;
        id_is_muldiv = md;
        flush        = fl;
        hold         = hd;
        #1;
        exp_stall = modelStall();
        checkOutput("stall", int'(stall), int'(exp_stall));
        checkOutput("fwd_a", int'(fwd_a), int'(modelFwd(id_rs)));
        checkOutput("fwd_b", int'(fwd_b), int'(modelFwd(id_rt)));
        checkOutput("muldiv_busy", int'(muldiv_busy), int'(modelBusy()));
    endtask

    // Commit the model for the current inputs, then take the clock edge.
    task automatic advance();
        logic enter;
        if (!hold) begin
            adv++;
            m_tag[2]  = m_tag[1];
            m_tag[1]  = m_tag[0];
            m_load[2] = m_load[1];
            m_load[1] = m_load[0];
            enter     = id_valid && !flush && !exp_stall;
            m_tag[0]  = enter ? id_wr : 6'd0;
            m_load[0] = enter ? id_is_load : 1'b0;
            if (enter && id_is_muldiv) last_md = adv;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pickTag();
        case ($urandom_range(0, 7))
            0:       return 6'd0;
            1:       return 6'd8;
            2:       return 6'd9;
            3:       return 6'd10;
            4:       return HILO;
            5:       return 6'd31;
            default: return 6'($urandom_range(1, 31));
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_wr = 0;
        id_is_load = 0; id_is_muldiv = 0; flush = 0; hold = 0;
        resetModel();
        #2;
        checkOutput("rst_stall", int'(stall), 0);
        checkOutput("rst_fwd_a", int'(fwd_a), 0);
        checkOutput("rst_fwd_b", int'(fwd_b), 0);
        checkOutput("rst_busy", int'(muldiv_busy), 0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle after reset.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_stall", int'(stall), 0);
        advance();

        // ALU producer then consumers at distance 1, 2, 3, 4.
        applyStimulus(1, 1, 2, 8, 0, 0, 0, 0);  advance();
        applyStimulus(1, 8, 0, 0, 0, 0, 0, 0);
        checkOutput("addu_fwd_a_ex", int'(fwd_a), 1);
        advance();
        applyStimulus(1, 0, 8, 0, 0, 0, 0, 0);
        checkOutput("addu_fwd_b_mem", int'(fwd_b), 2);
        advance();
        applyStimulus(1, 0, 8, 0, 0, 0, 0, 0);
        checkOutput("addu_fwd_b_wb", int'(fwd_b), 3);
        advance();
        applyStimulus(1, 0, 8, 0, 0, 0, 0, 0);
        checkOutput("addu_fwd_b_gone", int'(fwd_b), 0);
        advance();

        // Load-use: exactly one stall, then forward from MEM.
        applyStimulus(1, 0, 0, 9, 1, 0, 0, 0);  advance();
        applyStimulus(1, 0, 9, 11, 0, 0, 0, 0);
        checkOutput("ld_use_stall", int'(stall), 1);
        advance();
        applyStimulus(1, 0, 9, 11, 0, 0, 0, 0);
        checkOutput("ld_use_release", int'(stall), 0);
        checkOutput("ld_use_fwd_b", int'(fwd_b), 2);
        advance();

        // Tag 0 never matches, even against bubbles.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);  advance();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("zero_fwd_a", int'(fwd_a), 0);
        checkOutput("zero_stall", int'(stall), 0);
        advance();

        // MULTU then MFLO: four stall cycles, issue on the fifth.
        applyStimulus(1, 4, 5, HILO, 0, 1, 0, 0);  advance();
        for (int i = 0; i < MD_LAT; i++) begin
            applyStimulus(1, HILO, 0, 12, 0, 0, 0, 0);
            checkOutput("mflo_stall", int'(stall), 1);
            checkOutput("mflo_busy", int'(muldiv_busy), 1);
            advance();
        end
        applyStimulus(1, HILO, 0, 12, 0, 0, 0, 0);
        checkOutput("mflo_issue", int'(stall), 0);
        checkOutput("mflo_busy_done", int'(muldiv_busy), 0);
        advance();

        // Load-use squashed by flush: no stall, bubble enters EX.
        applyStimulus(1, 0, 0, 9, 1, 0, 0, 0);  advance();
        applyStimulus(1, 9, 0, 13, 0, 0, 1, 0);
        checkOutput("flush_stall", int'(stall), 0);
        advance();
        applyStimulus(1, 13, 9, 0, 0, 0, 0, 0);
        checkOutput("flush_bubble_a", int'(fwd_a), 0);
        checkOutput("flush_ld_b", int'(fwd_b), 2);
        advance();

        // Hold for three cycles mid-muldiv, then resume where it stopped.
        applyStimulus(1, 4, 5, HILO, 0, 1, 0, 0);  advance();
        applyStimulus(1, HILO, 0, 14, 0, 0, 0, 0);
        checkOutput("hold_pre_stall", int'(stall), 1);
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, HILO, 0, 14, 0, 0, 0, 1);
            checkOutput("hold_stall", int'(stall), 0);
            checkOutput("hold_busy", int'(muldiv_busy), 1);
            checkOutput("hold_fwd_a", int'(fwd_a), 2);
            advance();
        end
        for (int i = 0; i < MD_LAT - 1; i++) begin
            applyStimulus(1, HILO, 0, 14, 0, 0, 0, 0);
            checkOutput("resume_stall", int'(stall), 1);
            advance();
        end
        applyStimulus(1, HILO, 0, 14, 0, 0, 0, 0);
        checkOutput("resume_issue", int'(stall), 0);
        advance();

        // Reset asserted during a stall clears it without a clock edge.
        applyStimulus(1, 0, 0, 9, 1, 0, 0, 0);  advance();
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 0);
        checkOutput("pre_rst_stall", int'(stall), 1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_stall", int'(stall), 0);
        checkOutput("async_rst_fwd_a", int'(fwd_a), 0);
        id_valid = 0; id_rs = 0; id_wr = 0; id_is_load = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 9) != 0),
                          pickTag(), pickTag(), pickTag(),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 11) == 0));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Pipeline hazard unit sitting directly downstream of the ID-stage register-index decoder. It consumes the 6-bit read/write register tags per instruction (tag 0 = none/$zero, 1–31 = GPRs, 33 = HI/LO) and tracks the destination tags of instructions in EX, MEM and WB. From these it drives the stall and operand-forwarding selects, and a busy counter for the multi-cycle multiply/divide unit.

## Interface
- MULDIV_LAT, 32, cycles the mul/div unit is busy after a MULTU/DIVU enters EX (≥2).
- HILO_TAG, 6'd33, tag that denotes the HI/LO pair.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  6  ID read tag 1 (ReadRegister1).
- id_rt  in  6  ID read tag 2 (ReadRegister2).
- id_wr  in  6  ID write tag (WriteRegister).
- id_is_load  in  1  ID instruction is LW/LH/LHU/LB/LBU.
- id_is_muldiv  in  1  ID instruction is MULTU/DIVU.
- flush  in  1  squash the ID instruction (taken branch/jump).
- hold  in  1  global freeze (e.g. halted by SYSCALL).
- stall  out  1  hold PC and IF/ID; bubble into EX.
- fwd_a  out  2  source for operand A: 0 regfile, 1 EX result, 2 MEM result, 3 WB result.
- fwd_b  out  2  same encoding, for operand B.
- muldiv_busy  out  1  mul/div counter non-zero.

## Operation
- State: ex_tag, mem_tag, wb_tag (6 b each); ex_load, mem_load (1 b); busy_cnt (clog2(MULDIV_LAT+1) b).
- Hazard conditions (combinational, evaluated only when id_valid & ~flush & ~hold; tag 0 never matches):
  - load_use: ex_load & ex_tag≠0 & (ex_tag==id_rs | ex_tag==id_rt).
  - hilo_busy: busy_cnt≠0 & (id_rs==HILO_TAG | id_rt==HILO_TAG | id_wr==HILO_TAG | id_is_muldiv).
  - stall = load_use | hilo_busy.
- Forwarding, per operand (fwd_a uses id_rs, fwd_b uses id_rt), priority EX > MEM > WB:
  - 1 if ex_tag==src & src≠0 & ~ex_load.
  - else 2 if mem_tag==src & src≠0.
  - else 3 if wb_tag==src & src≠0.
  - else 0.
  - fwd outputs are computed regardless of stall; consumers ignore them during a stall.
- Per-clock update (when ~hold):
  - wb_tag ← mem_tag; mem_tag ← ex_tag; mem_load ← ex_load.
  - If id_valid & ~flush & ~stall: ex_tag ← id_wr, ex_load ← id_is_load. Otherwise ex_tag ← 0, ex_load ← 0 (bubble).
  - busy_cnt:
    - Load MULDIV_LAT when a muldiv enters EX (id_valid & id_is_muldiv & ~flush & ~stall).
    - Else decrement if non-zero.
    - Else hold at 0.
- hold=1: every register keeps its value, busy_cnt included; stall=0 and fwd stay combinationally valid.
- flush & a hazard in the same cycle: flush wins, stall=0, bubble enters EX.
- muldiv_busy = (busy_cnt≠0).

## Timing
- Reset (async, immediate): all tags 0, ex_load=mem_load=0, busy_cnt=0. Consequently stall=0, fwd_a=fwd_b=0, muldiv_busy=0.
- stall and fwd are same-cycle combinational from ID inputs and registered state; no internal input registering.
- Load-use costs exactly 1 stall cycle. On the following cycle the load is in MEM and fwd selects 2.
- A muldiv entering EX at edge N gives busy_cnt=MULDIV_LAT after N, reaching 0 after edge N+MULDIV_LAT. An HI/LO reader in ID stalls for MULDIV_LAT cycles, then issues.
- Reset asserted mid-stall clears stall in the same cycle (no clock needed).

## Test plan
- After reset release, idle inputs → stall=0, fwd_a=fwd_b=0, muldiv_busy=0; all tags read 0.
- ADDU writing tag 8, then ID reads id_rs=8 → fwd_a=1. One cycle later with id_rt=8 → fwd_b=2. Next cycle → fwd_b=3. Next → 0.
- LW writing tag 9, then ID reads id_rt=9 → stall=1 for 1 cycle with ex_tag=0 (bubble). Next cycle stall=0, fwd_b=2.
- Instruction with id_rs=0 while ex_tag=0 (bubble) or any stage writes tag 0 → fwd_a=0, stall=0.
- MULTU issued (MULDIV_LAT=4), then MFLO (id_rs=33) held in ID → stall=1 for 4 cycles, issues on the 5th; muldiv_busy=1 for exactly 4 cycles.
- Load-use with flush=1 → stall=0, ex_tag←0. Assert hold for 3 cycles mid-muldiv → busy_cnt and tags frozen, and resume exactly where they stopped.
